dshot_rx: RTL and testbench
===========================

DSHOT_RX -- requirements
Module: dshot_rx

Interface
REQ-001 SHALL have parameter CLK_HZ, default 16_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BIT_RATE, default 150_000, DShot bit rate in bit/s (150k/300k/600k/1200k).
REQ-003 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have port din  in  1  asynchronous DShot line.
REQ-006 SHALL have port frame_valid  out  1  one-cycle pulse per accepted frame.
REQ-007 SHALL have port throttle  out  11  last accepted 11-bit value.
REQ-008 SHALL have port telemetry  out  1  last accepted telemetry-request bit.
REQ-009 SHALL have port is_command  out  1  last accepted value in 0..47.
REQ-010 SHALL have port command  out  6  throttle[5:0] when is_command, else 0.
REQ-011 SHALL have port is_throttle  out  1  last accepted value in 48..2047.
REQ-012 SHALL have port crc_ok  out  1  CRC result of the most recent complete frame.
REQ-013 SHALL have port busy  out  1  a frame is in reception.
REQ-014 SHALL have port err_crc  out  1  one-cycle pulse on CRC mismatch.
REQ-015 SHALL have port err_timing  out  1  one-cycle pulse on pulse-width or gap violation.

Function
REQ-016 SHALL pass din through a 2-flop synchroniser; all edge detection uses the synchronised signal.
REQ-017 SHALL derive BIT_CYC = CLK_HZ/BIT_RATE and fail elaboration if BIT_CYC < 16.
REQ-018 SHALL implement states IDLE, HIGH, LOW; IDLE->HIGH on active edge, HIGH->LOW on inactive edge, LOW->HIGH on next active edge, LOW->IDLE after bit 16 or on timeout.
REQ-019 SHALL classify each high pulse: width > BIT_CYC/2 is 1, otherwise 0; width < BIT_CYC/8 or > 7*BIT_CYC/8 raises err_timing and returns to IDLE.
REQ-020 SHALL abort mid-frame when the line stays inactive for more than 2*BIT_CYC cycles, pulse err_timing, and return to IDLE.
REQ-021 SHALL shift bits MSB first; frame = throttle[10:0], telemetry, crc[3:0].
REQ-022 SHALL compute crc = (v ^ v>>4 ^ v>>8) & 0xF, where v is the upper 12 bits.
REQ-023 SHALL assert frame_valid, update all decode outputs and crc_ok=1 exactly 3 clk after the raw din inactive edge ending bit 16.
REQ-024 SHALL, on CRC mismatch, pulse err_crc at the same cycle instead, set crc_ok=0, and hold throttle/telemetry/is_command/command/is_throttle.
REQ-025 SHALL treat value 0 as is_command=1, command=0 (disarm).
REQ-026 SHALL assert busy from the first active edge until the return to IDLE.
REQ-027 SHALL accept back-to-back frames with no minimum inter-frame gap beyond one bit period.

Reset
REQ-028 SHALL, while rst is high, force IDLE, clear the bit counter and shift register, and drive all outputs to 0.
REQ-029 SHALL discard any partial frame when rst asserts mid-frame; reception restarts on the first active edge after rst deasserts.

Configuration
REQ-030 SHALL, with DSHOT_RX_INVERTED_EN defined, decode bidirectional DShot: line idle high, active level low, and expected crc is the bitwise complement of REQ-022.
REQ-031 SHALL, without DSHOT_RX_INVERTED_EN, decode standard DShot: idle low, active level high, crc as REQ-022.

Structure
REQ-032 SHALL place the frame field widths, the CMD_MAX=47 constant, and the CRC function in shared package dshot_pkg.
REQ-033 SHALL implement pulse-width measurement and bit classification in sub-module dshot_bit_timer; framing, CRC and output registers stay in dshot_rx.

Verification
REQ-034 SHALL cover: frame 0x82C6 at nominal timing -> one frame_valid pulse, throttle=1046, telemetry=0, crc_ok=1, is_throttle=1.
REQ-035 SHALL cover: frame 0x00BB -> is_command=1, command=5, telemetry=1, is_throttle=0.
REQ-036 SHALL cover: 0x82C6, then 0x82C7 -> err_crc pulse, no frame_valid, crc_ok=0, throttle holds 1046.
REQ-037 SHALL cover: 8 bits then line idle for 3*BIT_CYC -> err_timing pulse, busy=0; the following 0x82C6 decodes correctly.
REQ-038 SHALL cover: rst asserted after bit 10 -> all outputs 0 next cycle; the following 0x00BB decodes correctly.
REQ-039 SHALL cover: with DSHOT_RX_INVERTED_EN, inverted-line frame 0x82C9 -> frame_valid, throttle=1046, crc_ok=1; 0x82C6 -> err_crc.

Source files
------------

// File: rtl/dshot_pkg.sv
// dshot_pkg: shared DShot frame layout, command range, FSM states and CRC.
// Define DSHOT_RX_INVERTED_EN for bidirectional DShot (idle-high line, complemented CRC).
package dshot_pkg;
  localparam int FRAME_W = 16;
  localparam int THR_W = 11;
  localparam int CRC_W = 4;
  localparam int CMD_W = 6;
  localparam int CMD_MAX = 47;
`ifdef DSHOT_RX_INVERTED_EN
  localparam logic INVERTED = 1'b1;
`else
  localparam logic INVERTED = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
  function automatic logic [CRC_W-1:0] dshot_crc(input logic [FRAME_W-CRC_W-1:0] v);
    logic [CRC_W-1:0] c;
    c = v[3:0] ^ v[7:4] ^ v[11:8];
    return INVERTED ? ~c : c;
  endfunction
endpackage

// File: rtl/dshot_bit_timer.sv
// dshot_bit_timer: synchronises din, measures high/low run lengths and classifies bits.
//   clk, rst   : clock, synchronous active-high reset
//   din        : raw asynchronous DShot line
//   rise/fall  : active / inactive edge of the synchronised, polarity-normalised line
//   bit_val    : classification of the high pulse ending at fall
//   width_err  : pulse too short at fall, or still high past the maximum width
//   gap_err    : line inactive for more than 2*BIT_CYC cycles
module dshot_bit_timer
  import dshot_pkg::*;
#(
  parameter int BIT_CYC = 106
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall,
  output logic bit_val,
  output logic width_err,
  output logic gap_err
);
  localparam int CW = $clog2(2 * BIT_CYC + 1);
  localparam logic [CW-1:0] HALF = CW'(BIT_CYC / 2);
  localparam logic [CW-1:0] MIN_W = CW'(BIT_CYC / 8);
  localparam logic [CW-1:0] MAX_W = CW'(7 * BIT_CYC / 8);
  localparam logic [CW-1:0] GAP = CW'(2 * BIT_CYC);
  logic [2:0] sync;
  logic [CW-1:0] cnt;
  // The synchroniser keeps sampling through reset so no phantom edge appears on release.
  always_ff @(posedge clk) sync <= {sync[1:0], din ^ INVERTED};
  // cnt equals the length of the current run; at a fall it holds the full high width.
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else cnt <= (rise | fall) ? CW'(1) : (cnt == GAP ? cnt : cnt + CW'(1));
  always_comb begin
    rise = sync[1] & ~sync[2];
    fall = ~sync[1] & sync[2];
    bit_val = cnt > HALF;
    // cnt >= MAX_W while still high means the pulse already exceeds the maximum width.
    width_err = (fall & (cnt < MIN_W | cnt > MAX_W)) | (sync[1] & sync[2] & cnt >= MAX_W);
    gap_err = ~sync[1] & ~sync[2] & cnt >= GAP;
  end
endmodule

// File: rtl/dshot_rx.sv
// dshot_rx: DShot frame receiver with CRC check and decoded throttle/command outputs.
//   clk, rst    : clock, synchronous active-high reset
//   din         : asynchronous DShot line (polarity set by DSHOT_RX_INVERTED_EN)
//   frame_valid : one-cycle pulse per accepted frame
//   throttle, telemetry, is_command, command, is_throttle : last accepted frame
//   crc_ok      : CRC result of the most recent complete frame
//   busy        : frame in reception
//   err_crc, err_timing : one-cycle error pulses
module dshot_rx
  import dshot_pkg::*;
#(
  parameter int CLK_HZ = 16_000_000,
  parameter int BIT_RATE = 150_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  output logic             frame_valid,
  output logic [THR_W-1:0] throttle,
  output logic             telemetry,
  output logic             is_command,
  output logic [CMD_W-1:0] command,
  output logic             is_throttle,
  output logic             crc_ok,
  output logic             busy,
  output logic             err_crc,
  output logic             err_timing
);
  localparam int BIT_CYC = CLK_HZ / BIT_RATE;
  if (BIT_CYC < 16) begin : g_bit_cyc_check
    $error("dshot_rx: CLK_HZ/BIT_RATE must be at least 16");
  end
  logic rise, fall, bit_val, width_err, gap_err;
  state_t state;
  logic [3:0] nbit;
  logic [FRAME_W-2:0] sr;
  logic [FRAME_W-1:0] frame;
  logic [THR_W-1:0] thr;
  logic crc_good, cmd_val;
  dshot_bit_timer #(.BIT_CYC(BIT_CYC)) u_timer (
    .clk(clk),
    .rst(rst),
    .din(din),
    .rise(rise),
    .fall(fall),
    .bit_val(bit_val),
    .width_err(width_err),
    .gap_err(gap_err)
  );
  // frame is the complete word at the fall that ends bit 16.
  always_comb begin
    frame = {sr, bit_val};
    thr = frame[FRAME_W-1 -: THR_W];
    crc_good = dshot_crc(frame[FRAME_W-1:CRC_W]) == frame[CRC_W-1:0];
    cmd_val = thr <= THR_W'(CMD_MAX);
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      nbit <= '0;
      sr <= '0;
      frame_valid <= 1'b0;
      throttle <= '0;
      telemetry <= 1'b0;
      is_command <= 1'b0;
      command <= '0;
      is_throttle <= 1'b0;
      crc_ok <= 1'b0;
      busy <= 1'b0;
      err_crc <= 1'b0;
      err_timing <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      err_crc <= 1'b0;
      err_timing <= 1'b0;
      case (state)
        IDLE:
          if (rise) begin
            state <= HIGH;
            busy <= 1'b1;
            nbit <= '0;
            sr <= '0;
          end
        HIGH:
          if (width_err) begin
            state <= IDLE;
            busy <= 1'b0;
            err_timing <= 1'b1;
          end else if (fall) begin
            sr <= frame[FRAME_W-2:0];
            nbit <= nbit + 4'd1;
            state <= nbit == 4'd15 ? IDLE : LOW;
            if (nbit == 4'd15) begin
              busy <= 1'b0;
              crc_ok <= crc_good;
              err_crc <= ~crc_good;
              frame_valid <= crc_good;
              if (crc_good) begin
                throttle <= thr;
                telemetry <= frame[CRC_W];
                is_command <= cmd_val;
                command <= cmd_val ? thr[CMD_W-1:0] : '0;
                is_throttle <= ~cmd_val;
              end
            end
          end
        LOW:
          if (rise) state <= HIGH;
          else if (gap_err) begin
            state <= IDLE;
            busy <= 1'b0;
            err_timing <= 1'b1;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_dshot_rx.sv
// tb_dshot_rx: self-checking bench for dshot_rx (directed table, corner sequences, random frames).
module tb_dshot_rx;
`ifdef DSHOT_RX_INVERTED_EN
  localparam logic INV = 1'b1;
  localparam logic [15:0] XM = 16'h000F;
  localparam logic [15:0] BAD_W = 16'h82C6;
`else
  localparam logic INV = 1'b0;
  localparam logic [15:0] XM = 16'h0000;
  localparam logic [15:0] BAD_W = 16'h82C7;
`endif
  localparam int PER = 106;
  localparam int HI1 = 79;
  localparam int HI0 = 40;

  logic clk = 1'b0, rst = 1'b1, din = INV;
  logic frame_valid, telemetry, is_command, is_throttle, crc_ok, busy, err_crc, err_timing;
  logic [10:0] throttle;
  logic [5:0] command;
  int total = 0, bad = 0;
  int fv_cnt = 0, ec_cnt = 0, et_cnt = 0;

  typedef struct {
    logic [15:0] w;
    logic ok;
    logic [10:0] thr;
    logic tel;
    logic cf;
    logic [5:0] cmd;
    logic tf;
  } vec_t;
  vec_t vt[7];

  logic m_ok, m_tel, m_cf, m_tf;
  logic [10:0] m_thr;
  logic [5:0] m_cmd;

  dshot_rx #(.CLK_HZ(16_000_000), .BIT_RATE(150_000)) dut (
    .clk(clk),
    .rst(rst),
    .din(din),
    .frame_valid(frame_valid),
    .throttle(throttle),
    .telemetry(telemetry),
    .is_command(is_command),
    .command(command),
    .is_throttle(is_throttle),
    .crc_ok(crc_ok),
    .busy(busy),
    .err_crc(err_crc),
    .err_timing(err_timing)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_valid) fv_cnt++;
    if (err_crc) ec_cnt++;
    if (err_timing) et_cnt++;
  end

  task automatic chk(input string nm, input int got, input int want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endtask

  task automatic drive(input logic lvl, input int n);
    din = lvl ^ INV;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [15:0] w, input int nb, input int h1, input int h0, input int per);
    for (int i = 15; i > 15 - nb; i--) begin
      drive(1'b1, w[i] ? h1 : h0);
      drive(1'b0, per - (w[i] ? h1 : h0));
    end
  endtask

  function automatic logic crc_match(input logic [15:0] w);
    int v, c;
    v = int'(w) >> 4;
    c = (v ^ (v >> 4) ^ (v >> 8)) & 15;
    if (INV) c = 15 - c;
    return c == (int'(w) & 15);
  endfunction

  task automatic model_frame(input logic [15:0] w);
    m_ok = crc_match(w);
    if (m_ok) begin
      m_thr = 11'(int'(w) >> 5);
      m_tel = w[4];
      m_cf = int'(m_thr) <= 47;
      m_cmd = m_cf ? 6'(int'(m_thr) % 64) : 6'd0;
      m_tf = !m_cf;
    end
  endtask

  task automatic model_reset();
    m_ok = 0; m_thr = 0; m_tel = 0; m_cf = 0; m_cmd = 0; m_tf = 0;
  endtask

  task automatic check_frame(input string nm, input int fv0, input int ec0, input logic ok,
                             input logic [10:0] thr, input logic tel, input logic cf,
                             input logic [5:0] cmd, input logic tf);
    chk({nm, ".valid"}, fv_cnt - fv0, int'(ok));
    chk({nm, ".err_crc"}, ec_cnt - ec0, int'(!ok));
    chk({nm, ".crc_ok"}, int'(crc_ok), int'(ok));
    chk({nm, ".throttle"}, int'(throttle), int'(thr));
    chk({nm, ".telemetry"}, int'(telemetry), int'(tel));
    chk({nm, ".is_command"}, int'(is_command), int'(cf));
    chk({nm, ".command"}, int'(command), int'(cmd));
    chk({nm, ".is_throttle"}, int'(is_throttle), int'(tf));
    chk({nm, ".busy"}, int'(busy), 0);
  endtask

  task automatic check_model(input string nm, input int fv0, input int ec0);
    check_frame(nm, fv0, ec0, m_ok, m_thr, m_tel, m_cf, m_cmd, m_tf);
  endtask

  task automatic check_zero(input string nm);
    chk({nm, ".valid"}, int'(frame_valid), 0);
    chk({nm, ".throttle"}, int'(throttle), 0);
    chk({nm, ".telemetry"}, int'(telemetry), 0);
    chk({nm, ".is_command"}, int'(is_command), 0);
    chk({nm, ".command"}, int'(command), 0);
    chk({nm, ".is_throttle"}, int'(is_throttle), 0);
    chk({nm, ".crc_ok"}, int'(crc_ok), 0);
    chk({nm, ".busy"}, int'(busy), 0);
    chk({nm, ".err_crc"}, int'(err_crc), 0);
    chk({nm, ".err_timing"}, int'(err_timing), 0);
  endtask

  initial begin
    int fv0, ec0, et0;
    logic [15:0] w;
    int h1, h0, per;
    vt[0] = '{16'h82C6 ^ XM, 1'b1, 11'd1046, 1'b0, 1'b0, 6'd0, 1'b1};
    vt[1] = '{BAD_W, 1'b0, 11'd1046, 1'b0, 1'b0, 6'd0, 1'b1};
    vt[2] = '{16'h00BB ^ XM, 1'b1, 11'd5, 1'b1, 1'b1, 6'd5, 1'b0};
    vt[3] = '{16'h0000 ^ XM, 1'b1, 11'd0, 1'b0, 1'b1, 6'd0, 1'b0};
    vt[4] = '{16'hFFFF ^ XM, 1'b1, 11'd2047, 1'b1, 1'b0, 6'd0, 1'b1};
    vt[5] = '{16'h05EB ^ XM, 1'b1, 11'd47, 1'b0, 1'b1, 6'd47, 1'b0};
    vt[6] = '{16'h0606 ^ XM, 1'b1, 11'd48, 1'b0, 1'b0, 6'd0, 1'b1};
    model_reset();
    repeat (5) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    drive(1'b0, 10);

    foreach (vt[i]) begin
      fv0 = fv_cnt; ec0 = ec_cnt;
      send_bits(vt[i].w, 16, HI1, HI0, PER);
      model_frame(vt[i].w);
      check_frame($sformatf("vec%0d", i), fv0, ec0, vt[i].ok, vt[i].thr, vt[i].tel, vt[i].cf, vt[i].cmd, vt[i].tf);
    end

    w = 16'h82C6 ^ XM;
    fv0 = fv_cnt; ec0 = ec_cnt;
    send_bits(w, 15, HI1, HI0, PER);
    chk("lat.busy", int'(busy), 1);
    drive(1'b1, HI0);
    din = INV;
    @(negedge clk); @(negedge clk);
    chk("lat.cyc2", int'(frame_valid), 0);
    @(negedge clk);
    chk("lat.cyc3", int'(frame_valid), 1);
    @(negedge clk);
    chk("lat.cyc4", int'(frame_valid), 0);
    drive(1'b0, 60);
    model_frame(w);
    check_model("lat", fv0, ec0);

    et0 = et_cnt;
    drive(1'b1, 5);
    drive(1'b0, 300);
    chk("short.err_timing", et_cnt - et0, 1);
    chk("short.busy", int'(busy), 0);
    et0 = et_cnt;
    drive(1'b1, 100);
    drive(1'b0, 300);
    chk("long.err_timing", et_cnt - et0, 1);
    chk("long.busy", int'(busy), 0);

    et0 = et_cnt; fv0 = fv_cnt;
    send_bits(16'hFFFF, 8, HI1, HI0, PER);
    chk("gap.busy_mid", int'(busy), 1);
    drive(1'b0, 3 * PER);
    chk("gap.err_timing", et_cnt - et0, 1);
    chk("gap.busy", int'(busy), 0);
    chk("gap.no_valid", fv_cnt - fv0, 0);
    w = 16'h82C6 ^ XM;
    fv0 = fv_cnt; ec0 = ec_cnt;
    send_bits(w, 16, HI1, HI0, PER);
    model_frame(w);
    check_model("gap.next", fv0, ec0);

    send_bits(16'h00BB ^ XM, 10, HI1, HI0, PER);
    chk("rst.busy_mid", int'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    check_zero("rst_mid");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    drive(1'b0, 10);
    w = 16'h00BB ^ XM;
    fv0 = fv_cnt; ec0 = ec_cnt;
    send_bits(w, 16, HI1, HI0, PER);
    model_frame(w);
    check_model("rst.next", fv0, ec0);

    for (int i = 0; i < 12; i++) begin
      w = 16'($urandom);
      if ($urandom_range(0, 2) != 0)
        for (int c = 0; c < 16; c++) begin
          w[3:0] = 4'(c);
          if (crc_match(w)) break;
        end
      h1 = $urandom_range(60, 88);
      h0 = $urandom_range(16, 48);
      per = $urandom_range(h1 + 20, 130);
      fv0 = fv_cnt; ec0 = ec_cnt;
      send_bits(w, 16, h1, h0, per);
      model_frame(w);
      check_model($sformatf("rand%0d_%04h", i, w), fv0, ec0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
